// File: rtl/contador_de_programa_if.sv
// Control-unit to PC-stage bundle: next-PC controls in, fetch address and
// sequencing status out.
interface contador_de_programa_if #(
   parameter int PC_WIDTH   = 10,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
);
   logic                  pcReset;
   logic                  interrupt;
   logic                  isHalt;
   logic                  isInsert;
   logic [1:0]            pcSource;
   logic [PC_WIDTH-1:0]   jumpAddr;
   logic [DATA_WIDTH-1:0] regAddr;
   logic [PC_WIDTH-1:0]   pc;
   logic [PC_WIDTH-1:0]   pcPlusOne;
   logic [1:0]            state;
   logic                  resumePulse;
   logic                  addrError;
   logic [CNT_WIDTH-1:0]  instrCount;

   modport master (
      output pcReset, interrupt, isHalt, isInsert, pcSource, jumpAddr, regAddr,
      input  pc, pcPlusOne, state, resumePulse, addrError, instrCount
   );

   modport slave (
      input  pcReset, interrupt, isHalt, isInsert, pcSource, jumpAddr, regAddr,
      output pc, pcPlusOne, state, resumePulse, addrError, instrCount
   );
endinterface

// File: rtl/contador_de_programa.sv
// Program counter with RUN/HALT/WAIT_IN fetch sequencing, jal link value
// and retired-instruction counter.
//
// state   | meaning
// RUN     | fetching; each cycle with interrupt=0 retires one instruction
// HALT    | HALT executed; frozen until reset or pcReset
// WAIT_IN | IN executed; waiting for the input key (interrupt drops)
module contador_de_programa #(
   parameter int          PC_WIDTH   = 10,
   parameter int          DATA_WIDTH = 32,
   parameter int unsigned BOOT_ADDR  = 0,
   parameter int          CNT_WIDTH  = 32
) (
   input logic clock,
   input logic reset,
   contador_de_programa_if.slave bus
);
   typedef enum logic [1:0] {
      RUN     = 2'b00,
      HALT    = 2'b01,
      WAIT_IN = 2'b10
   } state_t;

   localparam logic [PC_WIDTH-1:0] BOOT_PC = PC_WIDTH'(BOOT_ADDR);

   state_t                state_q, state_nxt;
   logic [PC_WIDTH-1:0]   pc_q, pc_nxt, next_pc;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_nxt;
   logic                  err_q, err_nxt;
   logic                  pulse_q, pulse_nxt;
   logic                  jr_err;

   always_comb begin
      next_pc = pc_q + PC_WIDTH'(1);
      case (bus.pcSource)
         2'b01:   next_pc = bus.jumpAddr;
         2'b10:   next_pc = bus.regAddr[PC_WIDTH-1:0];
         2'b11:   next_pc = bus.jumpAddr;
         default: next_pc = pc_q + PC_WIDTH'(1);
      endcase
   end

   // jr targets beyond the instruction memory are truncated but flagged
   assign jr_err = (bus.pcSource == 2'b10) && (|bus.regAddr[DATA_WIDTH-1:PC_WIDTH]);

   always_comb begin
      state_nxt = state_q;
      pc_nxt    = pc_q;
      cnt_nxt   = cnt_q;
      err_nxt   = err_q;
      pulse_nxt = 1'b0;
      if (bus.pcReset) begin
         state_nxt = RUN;
         pc_nxt    = BOOT_PC;
         cnt_nxt   = '0;
         err_nxt   = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (!bus.interrupt) begin
                  pc_nxt  = next_pc;
                  cnt_nxt = cnt_q + CNT_WIDTH'(1);
                  err_nxt = err_q | jr_err;
               end else if (bus.isHalt) begin
                  state_nxt = HALT;
               end else if (bus.isInsert) begin
                  state_nxt = WAIT_IN;
               end
            end
            HALT: state_nxt = HALT;
            WAIT_IN: begin
               if (!bus.interrupt) begin
                  pc_nxt    = next_pc;
                  cnt_nxt   = cnt_q + CNT_WIDTH'(1);
                  err_nxt   = err_q | jr_err;
                  state_nxt = RUN;
                  pulse_nxt = 1'b1;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= BOOT_PC;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_nxt;
         pc_q    <= pc_nxt;
         cnt_q   <= cnt_nxt;
         err_q   <= err_nxt;
         pulse_q <= pulse_nxt;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.pcPlusOne   = pc_q + PC_WIDTH'(1);
   assign bus.state       = state_q;
   assign bus.resumePulse = pulse_q;
   assign bus.addrError   = err_q;
   assign bus.instrCount  = cnt_q;
endmodule
